// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit and the
// opcode/func control decoder it feeds.
//   IFU_RESET_PC      default first fetch address
//   ifu_state_e       fetch FSM states
//   OP_*/FUNC_*       instruction field slice positions
//   OP_J/OP_JAL/OP_BEQ opcode values shared with the decoder
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } ifu_state_e;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned FUNC_MSB = 5;
  localparam int unsigned FUNC_LSB = 0;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: bundles the fetch unit's bus signals.
//   imem_*     instruction memory request/grant/response channel
//   inst_*     buffered instruction towards the decoder (valid/ready)
//   redirect_* jump/taken-branch target from execute
// Modports: master = fetch unit side, slave = memory/decoder/execute side.
interface inst_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [5:0]        inst_op;
  logic [5:0]        inst_func;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst, inst_op, inst_func, inst_pc,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst, inst_op, inst_func, inst_pc,
    output inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO, DEPTH entries (power of two, >=2).
//   clk, rst_n  clock, asynchronous active-low reset
//   push_i      write wdata_i (ignored when full and not popping)
//   pop_i       drop head (ignored when empty)
//   flush_i     empty the FIFO; overrides push/pop
//   wdata_i     payload in
//   rdata_o     head payload
//   count_o     number of stored entries
module ifu_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, wptr_q;
  cnt_t             count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != cnt_t'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: holds the PC, issues word reads to instruction memory,
// buffers returned words and presents them to the control decoder.
// Jump/branch redirects flush the buffer; words of requests issued before a
// redirect are discarded while the FSM sits in DRAIN.
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   ifu         inst_fetch_unit_if.master (imem_*, inst_*, redirect_*)
// Optional feature macro IFU_PERF_CNT_EN adds:
//   perf_fetched  instructions consumed by the decoder (wraps)
//   perf_stall    FETCH cycles with no instruction presented (wraps)
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(IFU_RESET_PC),
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_fetch_unit_if.master    ifu
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   sum_t;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  cnt_t              out_q, out_d;     // outstanding = tag queue occupancy
  cnt_t              buf_count;
  logic              req, gnt_acc, rvalid_acc, push, pop, buf_valid;
  logic [ADDR_W-1:0] tag_head;
  logic [ADDR_W+31:0] head;
  logic [31:0]       inst_w;

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin : accounting
    gnt_acc    = req & ifu.imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rvalid_acc = ifu.imem_rvalid & (out_q != '0);
    out_d      = out_q + cnt_t'(gnt_acc) - cnt_t'(rvalid_acc);
    pc_d       = pc_q;
    if (ifu.redirect_valid)
      pc_d = {ifu.redirect_pc[ADDR_W-1:2], 2'b00};
    else if (gnt_acc)
      pc_d = pc_q + ADDR_W'(4);
    // The flush wins over a same-cycle response: that word is stale anyway.
    push = rvalid_acc & (state_q == FETCH) & ~ifu.redirect_valid;
    pop  = buf_valid & ifu.inst_ready;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (ifu.redirect_valid && (out_d != '0)) state_d = DRAIN;
      DRAIN:   if (out_d == '0) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // Request only depends on registered state, so once raised it can only be
  // withdrawn by a redirect moving the FSM to DRAIN.
  always_comb begin : outputs
    req = (state_q == FETCH) &&
          ((sum_t'(out_q) + sum_t'(buf_count)) < sum_t'(FIFO_DEPTH));
  end

  // Tags are never flushed: stale responses still retire their address.
  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (gnt_acc),
    .pop_i   (rvalid_acc),
    .flush_i (1'b0),
    .wdata_i (pc_q),
    .rdata_o (tag_head),
    .count_o (out_q)
  );

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + 32)
  ) u_inst_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (ifu.redirect_valid),
    .wdata_i ({tag_head, ifu.imem_rdata}),
    .rdata_o (head),
    .count_o (buf_count)
  );

  assign buf_valid     = (buf_count != '0);
  assign inst_w        = buf_valid ? head[31:0] : '0;
  assign ifu.imem_req  = req;
  assign ifu.imem_addr = pc_q;
  assign ifu.inst_valid = buf_valid;
  assign ifu.inst      = inst_w;
  assign ifu.inst_pc   = buf_valid ? head[ADDR_W+31:32] : '0;
  assign ifu.inst_op   = inst_w[OP_MSB:OP_LSB];
  assign ifu.inst_func = inst_w[FUNC_MSB:FUNC_LSB];

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin : perf_cnt
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (!buf_valid && (state_q == FETCH)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized bench for inst_fetch_unit with a
// transaction-level reference model (queues of in-flight and buffered
// addresses) plus directed scenarios pinned by literal expectations.
module tb_inst_fetch_unit;
  import ifu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(32)) bus ();
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  inst_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifu   (bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  pend_t       pend[$];      // granted, response not yet returned
  logic [31:0] exp_out[$];   // addresses expected in the instruction buffer
  logic [31:0] exp_req_pc;   // address of the next in-order request
  logic [31:0] popped[$];
  logic [31:0] granted[$];

  int gnt_pct, rv_pct, rdy_pct, redir_pct;
  bit redir_force;
  logic [31:0] redir_force_pc;
  bit d_gnt_acc, d_rvalid, d_pop, d_redir;
  logic [31:0] d_target;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic model_reset();
    pend.delete();
    exp_out.delete();
    exp_req_pc = 32'h0;
    d_gnt_acc = 0; d_rvalid = 0; d_pop = 0; d_redir = 0;
  endtask

  task automatic zero_inputs();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
  endtask

  // Apply the effect of the transactions driven in the previous cycle.
  task automatic account();
    pend_t e;
    if (d_pop && exp_out.size() != 0) void'(exp_out.pop_front());
    if (d_rvalid && pend.size() != 0) begin
      e = pend.pop_front();
      if (!e.stale && !d_redir) exp_out.push_back(e.addr);
    end
    if (d_gnt_acc) begin
      pend.push_back('{exp_req_pc, 1'b0});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (d_redir) begin
      exp_out.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_req_pc = {d_target[31:2], 2'b00};
    end
  endtask

  task automatic compare();
    bit any_stale;
    int occ;
    logic [31:0] w;
    any_stale = 0;
    foreach (pend[i]) if (pend[i].stale) any_stale = 1;
    occ = pend.size() + exp_out.size();
    chk("inst_valid", 32'(bus.inst_valid), 32'(exp_out.size() != 0));
    if (exp_out.size() != 0) begin
      w = memword(exp_out[0]);
      chk("inst_pc", bus.inst_pc, exp_out[0]);
      chk("inst", bus.inst, w);
      chk("inst_op", 32'(bus.inst_op), 32'(w[31:26]));
      chk("inst_func", 32'(bus.inst_func), 32'(w[5:0]));
    end
    chk("imem_req", 32'(bus.imem_req), 32'(!any_stale && occ < 2));
    if (bus.imem_req) chk("imem_addr", bus.imem_addr, exp_req_pc);
  endtask

  task automatic drive();
    bit g, rv, rdy, rd;
    logic [31:0] tgt;
    g   = ($urandom_range(99) < gnt_pct);
    rv  = (pend.size() != 0) && ($urandom_range(99) < rv_pct);
    rdy = ($urandom_range(99) < rdy_pct);
    rd  = 0;
    tgt = 32'h0;
    if (redir_force) begin
      rd = 1; tgt = redir_force_pc; redir_force = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      rd = 1; tgt = $urandom_range(0, 32'h0000_0FFF);
    end
    bus.imem_gnt       = g;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? memword(pend[0].addr) : $urandom;
    bus.inst_ready     = rdy;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rd ? tgt : $urandom;
    d_gnt_acc = bus.imem_req && g;
    if (d_gnt_acc) granted.push_back(bus.imem_addr);
    d_rvalid = rv;
    d_pop    = bus.inst_valid && rdy;
    if (d_pop) popped.push_back(bus.inst_pc);
    d_redir  = rd;
    d_target = tgt;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      account();
      compare();
      drive();
    end else begin
      zero_inputs();
      model_reset();
    end
  endtask

  task automatic knobs(input int g, input int rv, input int rdy, input int rd);
    gnt_pct = g; rv_pct = rv; rdy_pct = rdy; redir_pct = rd;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    zero_inputs();
    model_reset();
    redir_force = 0;
    knobs(100, 100, 100, 0);
    repeat (3) tick();
    chk("reset_req", 32'(bus.imem_req), 32'h0);
    chk("reset_valid", 32'(bus.inst_valid), 32'h0);
    chk("reset_inst", bus.inst, 32'h0);
    chk("reset_inst_pc", bus.inst_pc, 32'h0);
    rst_n = 1'b1;

    // Back-to-back fetch from reset.
    popped.delete();
    tick();
    chk("first_req", 32'(bus.imem_req), 32'h1);
    chk("first_addr", bus.imem_addr, 32'h0);
    repeat (19) tick();
    n = popped.size();
    chk("a_pops", 32'(n >= 3), 32'h1);
    if (n >= 3) begin
      chk("a_pc0", popped[0], 32'h0);
      chk("a_pc1", popped[1], 32'h4);
      chk("a_pc2", popped[2], 32'h8);
    end

    // Decoder stall: buffer fills, requests stop, nothing lost.
    knobs(100, 100, 0, 0);
    repeat (6) tick();
    chk("b_req_dropped", 32'(bus.imem_req), 32'h0);
    chk("b_valid_held", 32'(bus.inst_valid), 32'h1);
    knobs(100, 100, 100, 0);
    repeat (10) tick();
    foreach (popped[i]) chk("b_seq", popped[i], 32'(i * 4));

    // Redirect with two requests outstanding.
    knobs(100, 0, 100, 0);
    n = 0;
    do begin tick(); n++; end while (!(pend.size() == 2 && exp_out.size() == 0) && n < 20);
    if (n >= 20) timeout("c_two_outstanding");
    knobs(0, 0, 100, 0);
    redir_force = 1; redir_force_pc = 32'h43;
    tick();
    popped.delete();
    granted.delete();
    knobs(100, 100, 100, 0);
    n = 0;
    do begin tick(); n++; end while (popped.size() == 0 && n < 30);
    if (popped.size() == 0) timeout("c_refetch");
    else chk("c_first_pc", popped[0], 32'h40);
    if (granted.size() != 0) chk("c_first_gnt", granted[0], 32'h40);

    // Redirect coincident with a handshake and a grant.
    knobs(0, 100, 100, 0);
    n = 0;
    do begin tick(); n++; end while (!(pend.size() == 0 && exp_out.size() == 0) && n < 30);
    if (n >= 30) timeout("d_idle");
    granted.delete();
    popped.delete();
    knobs(100, 0, 0, 0);
    tick();
    knobs(0, 100, 0, 0);
    tick();
    knobs(100, 0, 100, 0);
    redir_force = 1; redir_force_pc = 32'h100;
    tick();
    chk("d_coincident", {29'h0, d_pop, d_gnt_acc, d_redir}, 32'h7);
    if (popped.size() != 0 && granted.size() != 0)
      chk("d_consumed_pc", popped[popped.size()-1], granted[0]);
    popped.delete();
    knobs(100, 100, 100, 0);
    n = 0;
    do begin tick(); n++; end while (popped.size() == 0 && n < 30);
    if (popped.size() == 0) timeout("d_refetch");
    else chk("d_first_pc", popped[0], 32'h100);

    // PC wrap at the top of the address space.
    redir_force = 1; redir_force_pc = 32'hFFFF_FFFC;
    tick();
    granted.delete();
    n = 0;
    do begin tick(); n++; end while (granted.size() < 2 && n < 40);
    if (granted.size() < 2) timeout("e_wrap");
    else begin
      chk("e_gnt_top", granted[0], 32'hFFFF_FFFC);
      chk("e_gnt_wrap", granted[1], 32'h0000_0000);
    end

    // Asynchronous reset in the middle of a burst.
    knobs(100, 0, 100, 0);
    n = 0;
    do begin tick(); n++; end while (pend.size() != 2 && n < 20);
    if (n >= 20) timeout("f_two_outstanding");
    #2 rst_n = 1'b0;
    zero_inputs();
    #1;
    chk("f_req_zero", 32'(bus.imem_req), 32'h0);
    chk("f_valid_zero", 32'(bus.inst_valid), 32'h0);
    chk("f_inst_zero", bus.inst, 32'h0);
    chk("f_pc_zero", bus.inst_pc, 32'h0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    granted.delete();
    knobs(100, 100, 100, 0);
    n = 0;
    do begin tick(); n++; end while (granted.size() == 0 && n < 10);
    if (granted.size() == 0) timeout("f_refetch");
    else chk("f_refetch_pc", granted[0], 32'h0);

    // Random traffic with occasional redirects.
    knobs(60, 60, 70, 3);
    repeat (3000) tick();
    knobs(100, 100, 100, 0);
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
